// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - exception/interrupt sequencer driving Cause/EPC writes, flush and PC redirect
module intr_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        int_req,
    input  logic        exc_ovf,
    input  logic        exc_ri,
    input  logic        exc_sys,
    input  logic        eret,
    input  logic [31:0] ex_pc,
    output logic        cause_write,
    output logic [31:0] cause_data,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        ie,
    output logic        in_handler,
    output logic        double_fault
);

    typedef enum logic [1:0] {S_IDLE, S_TAKE, S_HANDLER, S_RETURN} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [31:0]            r_saved_epc;

    logic        r_cause_write, r_epc_write, r_flush, r_pc_redirect;
    logic        r_ie, r_in_handler, r_double_fault;
    logic [31:0] r_cause_data, r_epc_data, r_redirect_pc;

    logic        w_cause_write, w_epc_write, w_flush, w_pc_redirect;
    logic        w_ie, w_in_handler, w_double_fault;
    logic [31:0] w_cause_data, w_epc_data, w_redirect_pc, w_saved_epc;

    logic        w_any_exc;
    logic        w_int_pend;
    logic        w_take;
    logic        w_ret;
    logic [1:0]  w_code;
    logic [31:0] w_epc;

    assign w_any_exc  = exc_ovf | exc_ri | exc_sys;
    assign w_int_pend = r_sync[SYNC_STAGES-1] & r_ie;
    assign w_take     = (r_state == S_IDLE) & ~stall & (w_any_exc | w_int_pend);
    assign w_ret      = (r_state == S_HANDLER) & ~stall & eret;

    always_comb begin
        if (exc_ovf)      w_code = 2'b11;
        else if (exc_ri)  w_code = 2'b10;
        else if (exc_sys) w_code = 2'b01;
        else              w_code = 2'b00;
    end

    // Syscall resumes after itself; faults and interrupts re-execute the EX instruction.
    assign w_epc = (w_code == 2'b01) ? ex_pc + 32'd4 : ex_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_take) w_next = S_TAKE;
            S_TAKE:    w_next = S_HANDLER;
            S_HANDLER: if (w_ret) w_next = S_RETURN;
            S_RETURN:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; pulses land in the cycle the new state is entered.
    always_comb begin
        w_cause_write  = 1'b0;
        w_epc_write    = 1'b0;
        w_flush        = 1'b0;
        w_pc_redirect  = 1'b0;
        w_cause_data   = r_cause_data;
        w_epc_data     = r_epc_data;
        w_redirect_pc  = r_redirect_pc;
        w_saved_epc    = r_saved_epc;
        w_ie           = r_ie;
        w_double_fault = r_double_fault;
        w_in_handler   = (w_next == S_HANDLER);
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_cause_write = 1'b1;
                    w_epc_write   = 1'b1;
                    w_flush       = 1'b1;
                    w_pc_redirect = 1'b1;
                    w_cause_data  = {28'b0, w_code, 2'b00};
                    w_epc_data    = w_epc;
                    w_saved_epc   = w_epc;
                    w_redirect_pc = HANDLER_ADDR;
                    w_ie          = 1'b0;
                end
            end
            S_HANDLER: begin
                if (~stall & w_any_exc) w_double_fault = 1'b1;
                if (w_ret) begin
                    w_flush       = 1'b1;
                    w_pc_redirect = 1'b1;
                    w_redirect_pc = r_saved_epc;
                    w_ie          = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync         <= '0;
            r_saved_epc    <= '0;
            r_cause_write  <= 1'b0;
            r_epc_write    <= 1'b0;
            r_flush        <= 1'b0;
            r_pc_redirect  <= 1'b0;
            r_cause_data   <= '0;
            r_epc_data     <= '0;
            r_redirect_pc  <= '0;
            r_ie           <= 1'b1;
            r_in_handler   <= 1'b0;
            r_double_fault <= 1'b0;
        end else begin
            r_sync         <= {r_sync[SYNC_STAGES-2:0], int_req};
            r_saved_epc    <= w_saved_epc;
            r_cause_write  <= w_cause_write;
            r_epc_write    <= w_epc_write;
            r_flush        <= w_flush;
            r_pc_redirect  <= w_pc_redirect;
            r_cause_data   <= w_cause_data;
            r_epc_data     <= w_epc_data;
            r_redirect_pc  <= w_redirect_pc;
            r_ie           <= w_ie;
            r_in_handler   <= w_in_handler;
            r_double_fault <= w_double_fault;
        end
    end

    assign cause_write  = r_cause_write;
    assign cause_data   = r_cause_data;
    assign epc_write    = r_epc_write;
    assign epc_data     = r_epc_data;
    assign flush        = r_flush;
    assign pc_redirect  = r_pc_redirect;
    assign redirect_pc  = r_redirect_pc;
    assign ie           = r_ie;
    assign in_handler   = r_in_handler;
    assign double_fault = r_double_fault;

endmodule
